gemm_tile_engine: RTL and testbench

Parametrised output-stationary int8 GEMM tile engine, successor to the fixed-size MAC grid and GEMM processor. One broadcast activation plus one weight per lane is consumed per beat, and each lane accumulates a signed dot product over K beats. The engine then requantises each lane (arithmetic shift, saturate, optional ReLU) and drains the results over a valid/ready stream. It sits between the activation/weight feeders and the layer writeback logic.

---
 rtl/gemm_tile_engine.sv | 196 +++++++++++++++++++
 tb/tb_gemm_tile_engine.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_tile_engine.sv
// gemm_tile_engine: output-stationary int8 GEMM tile engine.
// One broadcast activation and one weight per lane are consumed per beat. Each lane
// accumulates a signed dot product over k beats. The lanes are then requantised
// (arithmetic shift, saturate, optional ReLU) and drained one lane per cycle.
// Optional feature macro: GEMM_TILE_RELU_EN builds the ReLU stage and latches cmd_relu.
module gemm_tile_engine #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned K_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [K_W-1:0]            cmd_k,
    input  logic [4:0]                cmd_shift,
    input  logic                      cmd_relu,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_act,
    input  logic [LANES*DATA_W-1:0]   in_wgt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic [$clog2(LANES)-1:0]  out_lane,
    output logic                      out_last,
    output logic                      busy,
    output logic [15:0]               progress
);

    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DRAIN
    } state_t;

    state_t                   state_q, state_d;
    logic [K_W-1:0]           k_q, k_d;
    logic [K_W-1:0]           cnt_q, cnt_d;
    logic [4:0]               shift_q, shift_d;
    logic [15:0]              prog_d;
    logic [LANE_W-1:0]        lane_q, lane_d;
    logic signed [ACC_W-1:0]  acc_q [LANES];
    logic signed [ACC_W-1:0]  acc_d [LANES];
    logic signed [PROD_W-1:0] prod  [LANES];
    logic signed [DATA_W-1:0] act_s;
    logic                     cmd_fire;
    logic                     relu_d;

    assign act_s    = in_act;
    assign cmd_fire = cmd_valid && cmd_ready;

    // Shift, saturate to the output range, then optionally clip negatives to zero.
    function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] a,
                                                 input logic [4:0] sh,
                                                 input logic relu);
        logic signed [ACC_W-1:0] s;
        logic signed [ACC_W-1:0] c;
        s = a >>> sh;
        if (s > SAT_MAX) begin
            c = SAT_MAX;
        end else if (s < SAT_MIN) begin
            c = SAT_MIN;
        end else begin
            c = s;
        end
        if (relu && c[ACC_W-1]) begin
            c = '0;
        end
        return c[OUT_W-1:0];
    endfunction

    // Full-precision signed product per lane.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [DATA_W-1:0] wgt_s;
        assign wgt_s   = in_wgt[g*DATA_W +: DATA_W];
        assign prod[g] = PROD_W'(act_s) * PROD_W'(wgt_s);
    end

`ifdef GEMM_TILE_RELU_EN
    logic relu_q;
    assign relu_d = cmd_fire ? cmd_relu : relu_q;

    // ReLU enable latched with the command.
    always_ff @(posedge clk) begin
        if (reset) begin
            relu_q <= 1'b0;
        end else begin
            relu_q <= relu_d;
        end
    end
`else
    logic unused_relu;
    assign unused_relu = cmd_relu;
    assign relu_d      = 1'b0;
`endif

    // Next-state, accumulator, beat counter and drain lane logic.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        prog_d  = progress;
        lane_d  = lane_q;
        for (int i = 0; i < LANES; i++) begin
            acc_d[i] = acc_q[i];
        end
        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    k_d     = cmd_k;
                    shift_d = cmd_shift;
                    cnt_d   = '0;
                    prog_d  = '0;
                    lane_d  = '0;
                    for (int i = 0; i < LANES; i++) begin
                        acc_d[i] = '0;
                    end
                    state_d = (cmd_k == '0) ? DRAIN : ACC;
                end
            end
            ACC: begin
                if (in_valid && in_ready) begin
                    for (int i = 0; i < LANES; i++) begin
                        acc_d[i] = acc_q[i] + ACC_W'(prod[i]);
                    end
                    cnt_d = cnt_q + K_W'(1);
                    if (progress != 16'hFFFF) begin
                        prog_d = progress + 16'd1;
                    end
                    if (cnt_q == k_q - K_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    lane_d = lane_q + LANE_W'(1);
                    if (lane_q == LAST_LANE) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered outputs; outputs are computed from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            lane_q    <= '0;
            progress  <= '0;
            cmd_ready <= 1'b1;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lane  <= '0;
            out_last  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            lane_q    <= lane_d;
            progress  <= prog_d;
            cmd_ready <= (state_d == IDLE);
            in_ready  <= (state_d == ACC);
            busy      <= (state_d != IDLE);
            out_valid <= (state_d == DRAIN);
            out_lane  <= (state_d == DRAIN) ? lane_d : '0;
            out_last  <= (state_d == DRAIN) && (lane_d == LAST_LANE);
            out_data  <= (state_d == DRAIN) ? requant(acc_d[lane_d], shift_d, relu_d) : '0;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_gemm_tile_engine.sv
// Self-checking bench for gemm_tile_engine (default parameters, LANES=4).
module tb_gemm_tile_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_k;
    logic [4:0]  cmd_shift;
    logic        cmd_relu;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_act;
    logic [31:0] in_wgt;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_lane;
    logic        out_last;
    logic        busy;
    logic [15:0] progress;

    gemm_tile_engine dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k(cmd_k),
        .cmd_shift(cmd_shift), .cmd_relu(cmd_relu),
        .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wgt(in_wgt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lane(out_lane), .out_last(out_last), .busy(busy), .progress(progress)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]      k;
        logic [4:0]      shift;
        logic            relu;
        logic [3:0][7:0] act;
        logic [3:0][7:0] wgt;
        logic [3:0][7:0] exp;
    } vec_t;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] lane;
        logic       last;
    } exp_t;

    localparam int NVEC = 10;
`ifdef GEMM_TILE_RELU_EN
    localparam int RELU_NEG = 0;
`else
    localparam int RELU_NEG = 1;
`endif

    vec_t vt [NVEC];
    exp_t sb [$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   bp_hold = 0;
    bit   rand_bp = 1'b0;
    bit   chk_cr = 1'b0;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic [1:0] prev_lane;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int i, input int k, input int sh, input bit relu,
                           input int a0, input int a1, input int a2, input int a3,
                           input int w0, input int w1, input int w2, input int w3,
                           input int e0, input int e1, input int e2, input int e3);
        vt[i].k = 8'(k); vt[i].shift = 5'(sh); vt[i].relu = relu;
        vt[i].act[0] = 8'(a0); vt[i].act[1] = 8'(a1); vt[i].act[2] = 8'(a2); vt[i].act[3] = 8'(a3);
        vt[i].wgt[0] = 8'(w0); vt[i].wgt[1] = 8'(w1); vt[i].wgt[2] = 8'(w2); vt[i].wgt[3] = 8'(w3);
        vt[i].exp[0] = 8'(e0); vt[i].exp[1] = 8'(e1); vt[i].exp[2] = 8'(e2); vt[i].exp[3] = 8'(e3);
    endtask

    task automatic wait_cmd_ready();
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
    endtask

    task automatic issue_cmd(input int v, input bit push);
        wait_cmd_ready();
        cmd_valid = 1'b1;
        cmd_k     = vt[v].k;
        cmd_shift = vt[v].shift;
        cmd_relu  = vt[v].relu;
        if (push) begin
            for (int l = 0; l < 4; l++) begin
                sb.push_back({vt[v].exp[l], 2'(l), (l == 3)});
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("busy_after_cmd", busy, 1);
        check("in_ready_after_cmd", in_ready, (vt[v].k != 0) ? 1 : 0);
    endtask

    task automatic drive_beat(input int v, input int b, input bit gaps);
        while (gaps && ($urandom % 3 == 0)) begin
            in_valid = 1'b0;
            check("progress_hold_gap", progress, b);
            @(negedge clk);
        end
        check("in_ready_beat", in_ready, 1);
        in_valid = 1'b1;
        in_act   = vt[v].act[b];
        for (int l = 0; l < 4; l++) begin
            in_wgt[l*8 +: 8] = vt[v].wgt[l];
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_job(input int v, input bit gaps, input bit hold);
        int n = 0;
        issue_cmd(v, 1'b1);
        for (int b = 0; b < int'(vt[v].k); b++) begin
            drive_beat(v, b, gaps);
        end
        if (hold) bp_hold = 5;
        check("first_result_valid", out_valid, 1);
        check("first_result_lane", out_lane, 0);
        check("in_ready_in_drain", in_ready, 0);
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", sb.size(), 0);
        @(negedge clk);
        check("progress_final", progress, vt[v].k);
        check("busy_idle", busy, 0);
    endtask

    // Output side: drives out_ready, checks stalls, and pops the scoreboard on each transfer.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bp_hold > 0) begin
                out_ready = 1'b0;
                bp_hold--;
            end else begin
                out_ready = rand_bp ? ($urandom % 4 != 0) : 1'b1;
            end
            if (chk_cr) begin
                check("cmd_ready_after_last", cmd_ready, 1);
                chk_cr = 1'b0;
            end
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_lane", out_lane, prev_lane);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_lane  = out_lane;
            if (out_valid) check("cmd_ready_in_drain", cmd_ready, 0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", $signed(out_data), $signed(e.data));
                    check("out_lane", out_lane, e.lane);
                    check("out_last", out_last, e.last);
                    if (out_last) chk_cr = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_k = '0; cmd_shift = '0; cmd_relu = 1'b0;
        in_valid = 1'b0; in_act = '0; in_wgt = '0; out_ready = 1'b1;

        set_vec(0, 3, 0, 0,   1,   2,  3,   0,    1,  2,   3,    4,    6,  12,   18,   24);
        set_vec(1, 1, 0, 0, 127,   0,  0,   0,  127, 127, 127, 127,  127, 127,  127,  127);
        set_vec(2, 1, 7, 0, 127,   0,  0,   0,  127, 127, 127, 127,  126, 126,  126,  126);
        set_vec(3, 1, 0, 0, -128,  0,  0,   0,  127, 127, 127, 127, -128, -128, -128, -128);
        set_vec(4, 1, 0, 1,  -1,   0,  0,   0,    5,   5,   5,   5,
                RELU_NEG ? -5 : 0, RELU_NEG ? -5 : 0, RELU_NEG ? -5 : 0, RELU_NEG ? -5 : 0);
        set_vec(5, 0, 0, 0,   0,   0,  0,   0,    9,   9,   9,   9,    0,   0,    0,    0);
        set_vec(6, 4, 2, 0,  10, -20, 30, -40,    3,  -7, 100, -128, -15,  35, -128,  127);
        set_vec(7, 4, 2, 1,  10, -20, 30, -40,    3,  -7, 100, -128,
                RELU_NEG ? -15 : 0, 35, RELU_NEG ? -128 : 0, 127);
        set_vec(8, 2, 31, 0, 100, 100, 0,   0,    1,  -1,  50,  -50,    0,  -1,    0,   -1);
        set_vec(9, 2, 1, 0, -128, -128, 0,  0, -128, 127,  -1,    0,  127, -128,  127,    0);

        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_lane", out_lane, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_progress", progress, 0);

        run_job(0, 1'b0, 1'b0);
        run_job(0, 1'b0, 1'b1);
        run_job(0, 1'b1, 1'b0);
        run_job(5, 1'b0, 1'b0);

        rand_bp = 1'b1;
        for (int v = 0; v < NVEC; v++) begin
            run_job(v, ($urandom % 2) == 1, 1'b0);
        end
        rand_bp = 1'b0;

        // Reset after 2 of 4 beats discards the partial job.
        set_vec(NVEC - 1, 4, 0, 0, 1, 1, 1, 1, 1, 2, 3, 4, 0, 0, 0, 0);
        issue_cmd(NVEC - 1, 1'b0);
        drive_beat(NVEC - 1, 0, 1'b0);
        drive_beat(NVEC - 1, 1, 1'b0);
        check("progress_before_reset", progress, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_progress", progress, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        run_job(0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
